// File: rtl/zone_power_arbiter_if.sv
// Request/grant bundle between the zone temperature controllers and the power arbiter.
interface zone_power_arbiter_if #(
  parameter int NZONES = 4
);
  logic              tick;
  logic              en;
  logic [NZONES-1:0] req;
  logic [NZONES-1:0] grant;
  logic [3:0]        active_cnt;
  logic [NZONES-1:0] waiting;

  modport master (output tick, en, req, input grant, active_cnt, waiting);
  modport slave  (input tick, en, req, output grant, active_cnt, waiting);
endinterface

// File: rtl/zone_power_arbiter.sv
// Round-robin actuator power budget arbiter with per-zone min-on/min-off lockout.
// Optional macro ZONE_PREEMPT_EN: preempts the longest-on zone after MAX_ON ticks when others wait.
module zone_power_arbiter #(
  parameter int NZONES     = 4,
  parameter int MAX_ACTIVE = 2,
  parameter int MIN_ON     = 16,
  parameter int MIN_OFF    = 8,
  parameter int MAX_ON     = 64
) (
  input logic clk,
  input logic rst,
  zone_power_arbiter_if.slave bus
);
  typedef enum logic [1:0] {READY = 2'd0, ON = 2'd1, HOLD = 2'd2} zone_state_t;

  localparam int         IDX_W     = $clog2(NZONES);
  localparam logic [7:0] MIN_ON_C  = 8'(MIN_ON);
  localparam logic [7:0] MIN_OFF_C = 8'(MIN_OFF);
  localparam logic [3:0] MAX_ACT_C = 4'(MAX_ACTIVE);

  if (MAX_ON <= MIN_ON || MAX_ON > 255) begin : g_bad_max_on
    $error("MAX_ON must exceed MIN_ON and be at most 255");
  end

  zone_state_t       state     [NZONES];
  zone_state_t       state_nxt [NZONES];
  logic [7:0]        cnt       [NZONES];
  logic [7:0]        cnt_nxt   [NZONES];
  logic [IDX_W-1:0]  rr, rr_nxt;
  logic [NZONES-1:0] grant_q, grant_nxt;
  logic [NZONES-1:0] waiting_q, waiting_nxt;
  logic [3:0]        active_q, active_nxt;
  logic              win_vld;
  logic [IDX_W-1:0]  win_idx, cand_idx;
  logic              pre_vld;
  logic [IDX_W-1:0]  pre_idx;

  function automatic logic [7:0] dec_sat(input logic [7:0] v, input logic t);
    return (t && v != 8'd0) ? v - 8'd1 : v;
  endfunction

  function automatic logic [7:0] inc_sat(input logic [7:0] v, input logic t);
    return (t && v != 8'hFF) ? v + 8'd1 : v;
  endfunction

  function automatic logic [3:0] popcount(input logic [NZONES-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NZONES; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NZONES) s = s - NZONES;
    return IDX_W'(s);
  endfunction

  // Arbitration: budget is judged on the registered count, so a slot freed this edge is usable next cycle.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = rr;
    cand_idx = rr;
    if (bus.en && active_q < MAX_ACT_C) begin
      for (int k = 0; k < NZONES; k++) begin
        cand_idx = wrap_idx(rr, k);
        if (!win_vld && state[cand_idx] == READY && bus.req[cand_idx]) begin
          win_vld = 1'b1;
          win_idx = cand_idx;
        end
      end
    end
    rr_nxt = win_vld ? wrap_idx(win_idx, 1) : rr;
  end

`ifdef ZONE_PREEMPT_EN
  logic [7:0] ontime     [NZONES];
  logic [7:0] ontime_nxt [NZONES];
  logic [7:0] best;
  logic       found;

  // Longest-on zone; strict compare keeps the lowest index on ties.
  always_comb begin
    best    = '0;
    found   = 1'b0;
    pre_idx = '0;
    for (int i = 0; i < NZONES; i++) begin
      ontime_nxt[i] = (state[i] == ON) ? inc_sat(ontime[i], bus.tick) : 8'd0;
      if (state[i] == ON && (!found || ontime[i] > best)) begin
        found   = 1'b1;
        best    = ontime[i];
        pre_idx = IDX_W'(i);
      end
    end
    pre_vld = found && (best >= 8'(MAX_ON)) && (active_q == MAX_ACT_C) && (|waiting_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NZONES; i++) ontime[i] <= '0;
    end else begin
      for (int i = 0; i < NZONES; i++) ontime[i] <= ontime_nxt[i];
    end
  end
`else
  assign pre_vld = 1'b0;
  assign pre_idx = '0;
`endif

  // Per-zone state machine next state; loads take priority over the tick decrement.
  always_comb begin
    for (int i = 0; i < NZONES; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = dec_sat(cnt[i], bus.tick);
      case (state[i])
        READY: begin
          if (win_vld && win_idx == IDX_W'(i)) begin
            state_nxt[i] = ON;
            cnt_nxt[i]   = MIN_ON_C;
          end
        end
        ON: begin
          if (!bus.en || (pre_vld && pre_idx == IDX_W'(i)) ||
              (cnt[i] == 8'd0 && !bus.req[i])) begin
            state_nxt[i] = HOLD;
            cnt_nxt[i]   = MIN_OFF_C;
          end
        end
        HOLD: begin
          if (cnt[i] == 8'd0) state_nxt[i] = READY;
        end
        default: begin
          state_nxt[i] = READY;
          cnt_nxt[i]   = 8'd0;
        end
      endcase
      grant_nxt[i] = (state_nxt[i] == ON);
    end
    active_nxt = popcount(grant_nxt);
    for (int i = 0; i < NZONES; i++) begin
      waiting_nxt[i] = bus.en && bus.req[i] && (state_nxt[i] == READY) && (active_nxt >= MAX_ACT_C);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NZONES; i++) begin
        state[i] <= READY;
        cnt[i]   <= '0;
      end
      rr        <= '0;
      grant_q   <= '0;
      waiting_q <= '0;
      active_q  <= '0;
    end else begin
      for (int i = 0; i < NZONES; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
      rr        <= rr_nxt;
      grant_q   <= grant_nxt;
      waiting_q <= waiting_nxt;
      active_q  <= active_nxt;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.waiting    = waiting_q;
  assign bus.active_cnt = active_q;
endmodule

// File: doc/zone_power_arbiter.md
Name: zone_power_arbiter

Overview:
- Shares a limited actuator power budget among NZONES greenhouse zones.
- Each zone's temperature controller output drives one req bit. The arbiter grants at most MAX_ACTIVE actuators at once, in round-robin order.
- Enforces minimum on-time and minimum off-time (anti-short-cycle) per zone. Counters advance on a slow tick time base.
- Sits between the per-zone temperature controllers and the heater/cooler relay drivers.

Parameters:
- NZONES, 4, number of zones (2..8).
- MAX_ACTIVE, 2, maximum simultaneously granted zones (1..NZONES).
- MIN_ON, 16, minimum ticks a grant is held once issued (1..255).
- MIN_OFF, 8, lockout ticks after release before the zone may be re-granted (1..255).
- MAX_ON, 64, on-time limit used only by the optional feature (must be greater than MIN_ON, at most 255).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- tick  input  1  time-base strobe, one clk wide; all on/off counters decrement only when tick=1.
- en  input  1  global enable; 0 forces shutdown of all actuators.
- req  input  NZONES  per-zone actuation request (level).
- grant  output  NZONES  registered per-zone actuator enable.
- active_cnt  output  4  number of grant bits currently set.
- waiting  output  NZONES  registered; set where req=1, grant=0 and zone is READY but blocked by budget.

Behaviour:
- Reset (async, rst=1):
  - grant=0, active_cnt=0, waiting=0.
  - All zones in READY with counters=0.
  - Round-robin pointer rr=0.
- Per-zone state machine, 8-bit counter per zone:
  - READY: eligible when req=1 and en=1.
  - READY -> ON when selected by the arbiter. Counter loads MIN_ON; grant bit set next edge.
  - ON -> HOLD when counter=0 and req=0. Counter loads MIN_OFF; grant clears next edge.
  - ON with req=0 and counter>0: stays ON. Minimum on-time is enforced even if the request drops.
  - ON with req=1 and counter=0: stays ON indefinitely (base build).
  - HOLD -> READY when counter=0, independent of req.
  - Counters decrement on tick only and saturate at 0. No decrement occurs in the same cycle a counter is loaded.
- Arbitration, evaluated every clk:
  - At most one new grant per cycle.
  - Candidates: READY zones with req=1.
  - Allowed only if the registered active_cnt < MAX_ACTIVE.
  - Search starts at index rr, wrapping modulo NZONES. The first candidate wins and rr becomes winner+1 (mod NZONES). rr is unchanged if there is no winner.
  - A slot freed by a release in cycle N is usable by a new grant in cycle N+1, not N. No same-cycle release-and-grant.
- Latency: req rising in cycle N with budget available gives grant=1 after the edge ending cycle N (1 clk).
- active_cnt always equals popcount(grant); it updates on the same edge as grant.
- en=0:
  - All ON zones go to HOLD immediately, regardless of MIN_ON, loading MIN_OFF. grant=0 next edge.
  - No new grants; waiting=0.
  - HOLD countdown continues.
- en reasserted: zones still in HOLD finish their lockout before becoming eligible.
- Invalid states: any invalid per-zone state encoding recovers to READY on the next edge.

Optional Feature:
- Macro: ZONE_PREEMPT_EN.
- Defined:
  - Each ON zone also counts tick-based on-time since grant, saturating at 255.
  - When that count is >= MAX_ON, active_cnt == MAX_ACTIVE and any waiting bit is set, the longest-on zone is forced to HOLD with MIN_OFF loaded.
  - Ties are broken by lowest index. At most one preemption per cycle.
- Undefined: no on-time tracking; ON persists while req=1.

Test Plan:
- Reset then req=4'b0001, en=1: grant=4'b0001 one clk later; active_cnt=1. Drop req after 3 ticks: grant stays until 16 ticks elapsed, then clears. Zone 0 is not re-granted for 8 ticks even with req=1.
- req=4'b1111 from idle: grants issue one per clk to zone 0 then zone 1. active_cnt=2; waiting=4'b1100.
- In the 4'b1111 case, release zone 0 (req0=0 after MIN_ON): zone 2 is granted exactly 1 clk after grant0 clears, not in the same cycle. Zone 3 is granted after the next release (rr fairness).
- en=0 while grant=4'b0011 at tick 5 of MIN_ON: grant=0 next clk. Reassert en with req held: no grant until 8 ticks of lockout pass.
- tick held 0 for 100 clks with req=4'b0001 granted then dropped: grant stays 1 (no count without tick).
- With ZONE_PREEMPT_EN, MAX_ON=64 and req=4'b1111 held: zone 0 is preempted at tick 64 and zone 2 is granted next clk. Without the macro, grant stays 4'b0011 forever.
